// File: rtl/router_pkg.sv
// Shared types and defaults for the router control FSM and its wait timer.
package router_pkg;

  localparam int STATE_W          = 4;
  localparam int WAIT_CNT_W       = 8;
  localparam int DEF_NUM_CH       = 3;
  localparam int DEF_ADDR_W       = 2;
  localparam int DEF_WAIT_TIMEOUT = 32;

  typedef enum logic [STATE_W-1:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    WAIT_TILL_EMPTY,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    CHECK_PARITY_ERROR,
    DROP_PKT
  } state_t;

endpackage

// File: rtl/router_wait_timer.sv
// Saturating cycle counter bounding how long the router waits for a busy FIFO.
module router_wait_timer
  import router_pkg::*;
#(
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(WAIT_TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] cnt;

  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (v == {WAIT_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/router_ctrl_fsm.sv
// Packet router control FSM: header decode, FIFO write sequencing and drop handling.
// Define ROUTER_WAIT_TIMEOUT_EN to bound WAIT_TILL_EMPTY and raise timeout_err.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic              parity_done,
  input  logic              fifo_full,
  input  logic              low_pkt_valid,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic [ADDR_W-1:0] data_in,
  output logic              busy,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              drop_state,
  output logic              timeout_err,
  output logic [NUM_CH-1:0] dest_sel
);

  if (NUM_CH < 2 || NUM_CH > 16 || (2 ** ADDR_W) < NUM_CH) begin : g_bad_ch
    $error("router_ctrl_fsm: NUM_CH/ADDR_W out of range");
  end
  if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255) begin : g_bad_timeout
    $error("router_ctrl_fsm: WAIT_TIMEOUT out of range");
  end

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_ok;
  logic              hdr_empty;
  logic              cur_empty;
  logic              cur_soft;
  logic              expired;

  // Channel lookups by comparison so out-of-range headers never index past NUM_CH.
  always_comb begin
    addr_ok   = (int'(data_in) < NUM_CH);
    hdr_empty = 1'b0;
    cur_empty = 1'b0;
    cur_soft  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (data_in == ADDR_W'(i)) hdr_empty = fifo_empty[i];
      if (addr_q == ADDR_W'(i)) begin
        cur_empty = fifo_empty[i];
        cur_soft  = soft_reset[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid) addr_q <= data_in;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (!addr_ok)       next_state = DROP_PKT;
          else if (hdr_empty) next_state = LOAD_FIRST_DATA;
          else                next_state = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      WAIT_TILL_EMPTY: begin
        if (cur_empty)    next_state = LOAD_FIRST_DATA;
        else if (expired) next_state = DROP_PKT;
      end
      LOAD_DATA: begin
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      FIFO_FULL_STATE: begin
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      end
      CHECK_PARITY_ERROR: begin
        if (fifo_full) next_state = FIFO_FULL_STATE;
        else           next_state = DECODE_ADDRESS;
      end
      DROP_PKT: begin
        if (!pkt_valid) next_state = DECODE_ADDRESS;
      end
      default: next_state = DECODE_ADDRESS;
    endcase
    // Only the channel this packet targets may abort it.
    if (state != DECODE_ADDRESS && state != DROP_PKT && cur_soft) begin
      next_state = DECODE_ADDRESS;
    end
  end

`ifdef ROUTER_WAIT_TIMEOUT_EN
  router_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != WAIT_TILL_EMPTY),
    .enable (state == WAIT_TILL_EMPTY),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state == WAIT_TILL_EMPTY) && (next_state == DROP_PKT);
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA) || (state == LOAD_PARITY);
  assign write_enb_reg = (state == LOAD_FIRST_DATA) || (state == LOAD_DATA) ||
                         (state == LOAD_PARITY);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign drop_state    = (state == DROP_PKT);
  assign busy          = (state == LOAD_FIRST_DATA) || (state == WAIT_TILL_EMPTY) ||
                         (state == LOAD_PARITY) || (state == FIFO_FULL_STATE) ||
                         (state == LOAD_AFTER_FULL) || (state == CHECK_PARITY_ERROR);

  always_comb begin
    dest_sel = '0;
    if (state != DECODE_ADDRESS && state != DROP_PKT) begin
      for (int i = 0; i < NUM_CH; i++) dest_sel[i] = (addr_q == ADDR_W'(i));
    end
  end

endmodule
